// File: rtl/exit_pay_fsm.sv
// Exit-lane pay station: reads the entry ticket, computes the parking fee, takes $2/$4 bills,
// then blinks the thank-you lamp and opens the exit gate. Faults latch until an attendant clears.
module exit_pay_fsm #(
   parameter int unsigned DWIDTH        = 16,
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned RATE_MIN      = 60,
   parameter int unsigned RATE_DOLLARS  = 2,
   parameter int unsigned FEE_MAX       = 98,
   parameter int unsigned READ_TMO_SEC  = 3,
   parameter int unsigned PAY_TMO_SEC   = 60,
   parameter int unsigned GATE_SEC      = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              exit_sensor,
   input  logic              ticket_inserted,
   input  logic              ticket_valid,
   input  logic              ticket_ok,
   input  logic [DWIDTH-1:0] parking_time_min,
   input  logic              bill_2,
   input  logic              bill_4,
   input  logic              attendant_clr,
   output logic [7:0]        fee_bcd,
   output logic [7:0]        change_due,
   output logic              thank_you_lamp,
   output logic              see_attendant_lamp,
   output logic              exit_gate
);

   localparam int unsigned HalfTicks = TICKS_PER_SEC / 2;
   localparam int unsigned PW        = (HalfTicks > 1) ? $clog2(HalfTicks) : 1;

   localparam logic [PW-1:0]     PrescLast = PW'(HalfTicks - 1);
   localparam logic [7:0]        ReadLast  = 8'(2 * READ_TMO_SEC - 1);
   localparam logic [7:0]        PayLast   = 8'(2 * PAY_TMO_SEC - 1);
   localparam logic [7:0]        GateLast  = 8'(2 * GATE_SEC - 1);
   localparam logic [DWIDTH-1:0] RateMinW  = DWIDTH'(RATE_MIN);
   localparam logic [6:0]        FeeMaxW   = 7'(FEE_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCalc,
      StWaitPay,
      StThanks,
      StGateOpen,
      StError
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [7:0]        timer_q, timer_d;
   logic [DWIDTH-1:0] rem_q, rem_d;
   logic [6:0]        fee_q, fee_d;
   logic [7:0]        fee_bcd_q, fee_bcd_d;
   logic [7:0]        change_q, change_d;
   logic              lamp_q, lamp_d;
   logic              attn_q, attn_d;
   logic              gate_q, gate_d;

   logic       half_tick;
   logic       restart;
   logic [6:0] credit;
   logic [7:0] fee_sum;

   assign half_tick = (presc_q == PrescLast);
   assign credit    = {4'd0, bill_4, bill_2, 1'b0};
   assign fee_sum   = {1'b0, fee_q} + 8'(RATE_DOLLARS);

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      fee_d    = fee_q;
      change_d = change_q;
      restart  = 1'b0;

      case (state_q)
         StIdle: begin
            fee_d = '0;
            if (exit_sensor && ticket_inserted) begin
               state_d  = StRead;
               change_d = '0;
            end
         end
         StRead: begin
            if (ticket_valid) begin
               if (ticket_ok) begin
                  state_d = StCalc;
                  rem_d   = parking_time_min;
               end else begin
                  state_d = StError;
               end
            end else if (half_tick && timer_q == ReadLast) begin
               state_d = StError;
            end
         end
         StCalc: begin
            // One billing period per cycle; stop early once the cap is reached.
            if (rem_q == '0 || fee_q == FeeMaxW) begin
               state_d = (fee_q == '0) ? StThanks : StWaitPay;
            end else begin
               rem_d = (rem_q > RateMinW) ? rem_q - RateMinW : '0;
               fee_d = (fee_sum >= {1'b0, FeeMaxW}) ? FeeMaxW : fee_sum[6:0];
            end
         end
         StWaitPay: begin
            if (credit != '0) begin
               restart = 1'b1;
               if (credit >= fee_q) begin
                  change_d = {1'b0, credit - fee_q};
                  fee_d    = '0;
                  state_d  = StThanks;
               end else begin
                  fee_d = fee_q - credit;
               end
            end else if (half_tick && timer_q == PayLast) begin
               state_d = StError;
            end
         end
         StThanks: begin
            if (half_tick && timer_q == 8'd3) begin
               state_d = StGateOpen;
            end
         end
         StGateOpen: begin
            if (!exit_sensor || (half_tick && timer_q == GateLast)) begin
               state_d = StIdle;
            end
         end
         StError: begin
            if (attendant_clr) begin
               state_d = StIdle;
               fee_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Prescaler and timer realign on every state entry so phases start on a clean half-second.
   always_comb begin
      presc_d = presc_q + PW'(1);
      timer_d = timer_q;
      if (state_d != state_q || restart) begin
         presc_d = '0;
         timer_d = '0;
      end else if (half_tick) begin
         presc_d = '0;
         timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
      end
   end

   always_comb begin
      fee_bcd_d = {4'(fee_q / 7'd10), 4'(fee_q % 7'd10)};
      lamp_d    = (state_d == StThanks) && (timer_d == 8'd0 || timer_d == 8'd2);
      attn_d    = (state_d == StError);
      gate_d    = (state_d == StGateOpen);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         timer_q   <= '0;
         rem_q     <= '0;
         fee_q     <= '0;
         fee_bcd_q <= '0;
         change_q  <= '0;
         lamp_q    <= 1'b0;
         attn_q    <= 1'b0;
         gate_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         timer_q   <= timer_d;
         rem_q     <= rem_d;
         fee_q     <= fee_d;
         fee_bcd_q <= fee_bcd_d;
         change_q  <= change_d;
         lamp_q    <= lamp_d;
         attn_q    <= attn_d;
         gate_q    <= gate_d;
      end
   end

   assign fee_bcd            = fee_bcd_q;
   assign change_due         = change_q;
   assign thank_you_lamp     = lamp_q;
   assign see_attendant_lamp = attn_q;
   assign exit_gate          = gate_q;

endmodule

// File: tb/tb_exit_pay_fsm.sv
// Bench for exit_pay_fsm: directed transactions drive a fee/lamp/gate expectation model that is
// compared against the DUT outputs on every falling edge.
module tb_exit_pay_fsm;

   localparam int RATE = 60;
   localparam int FMAX = 98;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        exit_sensor, ticket_inserted, ticket_valid, ticket_ok;
   logic [15:0] parking_time_min;
   logic        bill_2, bill_4, attendant_clr;
   logic [7:0]  fee_bcd, change_due;
   logic        thank_you_lamp, see_attendant_lamp, exit_gate;

   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;

   int         m_fee = 0;
   logic [7:0] exp_bcd = 8'h00;
   logic [7:0] exp_change = 8'h00;
   logic       exp_lamp = 1'b0;
   logic       exp_attn = 1'b0;
   logic       exp_gate = 1'b0;

   exit_pay_fsm #(
      .DWIDTH        (16),
      .TICKS_PER_SEC (20)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .exit_sensor        (exit_sensor),
      .ticket_inserted    (ticket_inserted),
      .ticket_valid       (ticket_valid),
      .ticket_ok          (ticket_ok),
      .parking_time_min   (parking_time_min),
      .bill_2             (bill_2),
      .bill_4             (bill_4),
      .attendant_clr      (attendant_clr),
      .fee_bcd            (fee_bcd),
      .change_due         (change_due),
      .thank_you_lamp     (thank_you_lamp),
      .see_attendant_lamp (see_attendant_lamp),
      .exit_gate          (exit_gate)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check8("fee_bcd", fee_bcd, exp_bcd);
         check8("change_due", change_due, exp_change);
         check8("thank_you_lamp", {7'd0, thank_you_lamp}, {7'd0, exp_lamp});
         check8("see_attendant_lamp", {7'd0, see_attendant_lamp}, {7'd0, exp_attn});
         check8("exit_gate", {7'd0, exit_gate}, {7'd0, exp_gate});
      end
   end

   // One clock; the displayed fee trails the internal fee by one cycle.
   task automatic cyc();
      int prev;
      prev = m_fee;
      @(posedge clk);
      #1;
      exp_bcd = to_bcd(prev);
   endtask

   task automatic run_ticket(input int t);
      int steps;
      exit_sensor     = 1'b1;
      ticket_inserted = 1'b1;
      cyc();
      exp_change = 8'h00;
      ticket_ok        = 1'b1;
      ticket_valid     = 1'b1;
      parking_time_min = 16'(t);
      cyc();
      ticket_valid = 1'b0;
      // Every started hour costs $2; the cap is hit after FMAX/2 periods.
      steps = (t + RATE - 1) / RATE;
      if (steps > FMAX / 2) steps = FMAX / 2;
      for (int i = 1; i <= steps; i++) begin
         cyc();
         m_fee = (2 * i > FMAX) ? FMAX : 2 * i;
      end
      cyc();
      if (m_fee == 0) exp_lamp = 1'b1;
   endtask

   task automatic pay(input bit b2, input bit b4);
      int credit;
      bill_2 = b2;
      bill_4 = b4;
      cyc();
      bill_2 = 1'b0;
      bill_4 = 1'b0;
      credit = 2 * int'(b2) + 4 * int'(b4);
      if (credit >= m_fee) begin
         exp_change = 8'(credit - m_fee);
         m_fee      = 0;
         exp_lamp   = 1'b1;
      end else begin
         m_fee = m_fee - credit;
      end
   endtask

   task automatic thanks_gate();
      for (int k = 1; k <= 40; k++) begin
         cyc();
         exp_lamp = (k < 10) || (k >= 20 && k < 30);
         if (k == 40) exp_gate = 1'b1;
      end
   endtask

   task automatic leave_gate();
      ticket_inserted = 1'b0;
      exit_sensor     = 1'b0;
      cyc();
      exp_gate = 1'b0;
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check8("rst_fee_bcd", fee_bcd, 8'h00);
      check8("rst_change", change_due, 8'h00);
      check8("rst_lamp", {7'd0, thank_you_lamp}, 8'h00);
      check8("rst_attn", {7'd0, see_attendant_lamp}, 8'h00);
      check8("rst_gate", {7'd0, exit_gate}, 8'h00);
      m_fee = 0; exp_bcd = 8'h00; exp_change = 8'h00;
      exp_lamp = 1'b0; exp_attn = 1'b0; exp_gate = 1'b0;
      exit_sensor = 1'b0; ticket_inserted = 1'b0; ticket_valid = 1'b0;
      bill_2 = 1'b0; bill_4 = 1'b0; attendant_clr = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      exit_sensor = 1'b0; ticket_inserted = 1'b0; ticket_valid = 1'b0; ticket_ok = 1'b0;
      parking_time_min = 16'd0; bill_2 = 1'b0; bill_4 = 1'b0; attendant_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check8("init_fee_bcd", fee_bcd, 8'h00);
      check8("init_gate", {7'd0, exit_gate}, 8'h00);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      cyc();

      // Normal flow: 125 min -> $6, pay $4 then $2.
      run_ticket(125);
      check8("t125_fee_bcd", fee_bcd, 8'h06);
      pay(1'b0, 1'b1);
      pay(1'b1, 1'b0);
      check8("t125_paid_bcd", fee_bcd, 8'h02);
      check8("t125_lamp_on", {7'd0, thank_you_lamp}, 8'h01);
      thanks_gate();
      check8("t125_gate_open", {7'd0, exit_gate}, 8'h01);
      leave_gate();
      check8("t125_gate_closed", {7'd0, exit_gate}, 8'h00);

      // Bad ticket: lane locks; bills ignored; attendant clears.
      exit_sensor = 1'b1; ticket_inserted = 1'b1;
      cyc();
      ticket_ok = 1'b0; ticket_valid = 1'b1;
      cyc();
      ticket_valid = 1'b0;
      exp_attn = 1'b1;
      check8("bad_attn", {7'd0, see_attendant_lamp}, 8'h01);
      check8("bad_gate", {7'd0, exit_gate}, 8'h00);
      bill_4 = 1'b1;
      cyc();
      bill_4 = 1'b0;
      exit_sensor = 1'b0; ticket_inserted = 1'b0; attendant_clr = 1'b1;
      cyc();
      attendant_clr = 1'b0;
      exp_attn = 1'b0;
      cyc();

      // Reader never answers: lockout after 3 s (60 cycles).
      exit_sensor = 1'b1; ticket_inserted = 1'b1;
      cyc();
      for (int k = 1; k <= 60; k++) begin
         cyc();
         if (k == 60) exp_attn = 1'b1;
      end
      exit_sensor = 1'b0; ticket_inserted = 1'b0; attendant_clr = 1'b1;
      cyc();
      attendant_clr = 1'b0;
      exp_attn = 1'b0;
      cyc();

      // Zero minutes: straight to the thank-you sequence.
      run_ticket(0);
      check8("t0_fee_bcd", fee_bcd, 8'h00);
      thanks_gate();
      leave_gate();

      // Long stay: fee capped, then reset mid-payment.
      run_ticket(3000);
      check8("t3000_cap", fee_bcd, 8'h98);
      cyc();
      do_reset();
      cyc();

      // Overpay yields change; reset while the gate is open.
      run_ticket(61);
      pay(1'b1, 1'b0);
      pay(1'b1, 1'b1);
      check8("t61_change", change_due, 8'd4);
      thanks_gate();
      do_reset();
      cyc();

      // Both bills together cover $6 exactly.
      run_ticket(125);
      pay(1'b1, 1'b1);
      check8("both_change", change_due, 8'd0);
      check8("both_lamp", {7'd0, thank_you_lamp}, 8'h01);
      thanks_gate();
      leave_gate();

      // Payment timeout: bill restarts timer, then 1200 idle cycles -> ERROR; fee held.
      run_ticket(125);
      pay(1'b1, 1'b0);
      for (int k = 1; k <= 1200; k++) begin
         cyc();
         if (k == 1200) exp_attn = 1'b1;
      end
      check8("tmo_attn", {7'd0, see_attendant_lamp}, 8'h01);
      bill_4 = 1'b1;
      cyc();
      bill_4 = 1'b0;
      check8("tmo_fee_held", fee_bcd, 8'h04);
      exit_sensor = 1'b0; ticket_inserted = 1'b0; attendant_clr = 1'b1;
      cyc();
      attendant_clr = 1'b0;
      exp_attn = 1'b0;
      m_fee    = 0;
      cyc();
      cyc();
      check8("clr_fee_bcd", fee_bcd, 8'h00);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
